// File: rtl/spi_byte_master.sv
// -----------------------------------------------------------------------------
// spi_byte_master
//
// Byte-wide SPI master used for ADC register access behind command_processor.
// One byte is accepted per spitxdv strobe while spitxready=1. The byte is shifted
// out MSB first on spi_mosi. The byte captured from spi_miso comes back on spirx
// together with a one-cycle spirxdv pulse. Chip select is driven by
// command_processor, so this block drives only SCLK and MOSI and samples MISO.
//
// Parameters
//   CLKS_PER_HALF_BIT  clk cycles per SCLK half-period (must be >= 2)
//   SPI_MODE           0..3, CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]
//
// Ports
//   clk         in   system clock, all logic on posedge
//   rst         in   asynchronous, active-high reset
//   spitx       in   [7:0] byte to transmit, sampled on accept
//   spitxdv     in   transmit strobe, ignored while spitxready=0
//   spitxready  out  1 = idle or finishing, next spitxdv is accepted
//   spirx       out  [7:0] last received byte, held until the next spirxdv
//   spirxdv     out  one-cycle pulse, spirx is valid
//   spi_sclk    out  SPI clock, idles at CPOL
//   spi_mosi    out  SPI data out, MSB first
//   spi_miso    in   SPI data in, already timed to the clk domain
//
// Configuration macro
//   SPI_LOOPBACK_EN  when defined, the sampler takes the internal MOSI bit
//                    instead of spi_miso, so spirx echoes the transmitted byte.
//                    SCLK and MOSI are still driven normally. Used for bring-up
//                    without the ADC.
// -----------------------------------------------------------------------------
module spi_byte_master #(
   parameter int CLKS_PER_HALF_BIT = 2,
   parameter int SPI_MODE          = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] spitx,
   input  logic       spitxdv,
   output logic       spitxready,
   output logic [7:0] spirx,
   output logic       spirxdv,
   output logic       spi_sclk,
   output logic       spi_mosi,
   input  logic       spi_miso
);

   localparam bit CPOL  = ((SPI_MODE / 2) % 2) == 1;
   localparam bit CPHA  = (SPI_MODE % 2) == 1;
   localparam int CNT_W = (CLKS_PER_HALF_BIT > 2) ? $clog2(CLKS_PER_HALF_BIT) : 1;

   if (CLKS_PER_HALF_BIT < 2) begin : g_bad_half_bit
      $error("spi_byte_master: CLKS_PER_HALF_BIT must be >= 2");
   end
   if (SPI_MODE < 0 || SPI_MODE > 3) begin : g_bad_mode
      $error("spi_byte_master: SPI_MODE must be 0..3");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic             init_done;   // low until the first clk after reset release
   logic [CNT_W-1:0] half_cnt;
   logic [4:0]       edge_cnt;    // number of SCLK edges already issued, 0..16
   logic [7:0]       tx_sr;
   logic [7:0]       rx_sr;
   logic [7:0]       rx_next;
   logic [7:0]       spirx_q;
   logic             sclk_q;
   logic             mosi_q;
   logic             miso_src;
   logic             accept;
   logic             half_tc;
   logic             sample_now;
   logic             shift_now;
   logic             last_edge;

`ifdef SPI_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = spi_miso;
   assign miso_src    = mosi_q;
`else
   assign miso_src    = spi_miso;
`endif

   // The DONE cycle also reports ready, which lets back-to-back bytes run with
   // no idle gap.
   assign spitxready = init_done && (state != SHIFT);
   assign accept     = spitxready && spitxdv;
   assign spirxdv    = (state == DONE);
   assign spirx      = spirx_q;
   assign spi_sclk   = sclk_q;
   assign spi_mosi   = mosi_q;

   // half_tc marks the cycle on which SCLK toggles. edge_cnt still holds the
   // count before this edge, so the edge about to happen is number edge_cnt+1.
   // CPHA=0 samples on odd edges and shifts on even edges 2..14.
   // CPHA=1 shifts on odd edges and samples on even edges.
   assign half_tc    = (state == SHIFT) && (half_cnt == CNT_W'(CLKS_PER_HALF_BIT - 1));
   assign sample_now = half_tc && (edge_cnt[0] == CPHA);
   assign shift_now  = half_tc && (edge_cnt[0] != CPHA) && (CPHA || edge_cnt != 5'd15);
   assign last_edge  = half_tc && (edge_cnt == 5'd15);
   assign rx_next    = sample_now ? {rx_sr[6:0], miso_src} : rx_sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      // NOTE: assigning a default before the case means every path drives
      //       next_state, so no latch is inferred.
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = SHIFT;
         SHIFT:   if (last_edge) next_state = DONE;
         DONE:    next_state = accept ? SHIFT : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only. Every register
   //       reads the pre-edge value of the others, so statement order inside
   //       the block does not matter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the whole datapath is reset, not just the control. A
         //       mid-byte abort must leave no partial rx data, and SCLK
         //       must return to CPOL right away.
         init_done <= 1'b0;
         half_cnt  <= '0;
         edge_cnt  <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         spirx_q   <= '0;
         sclk_q    <= CPOL;
         mosi_q    <= 1'b0;
      end else begin
         init_done <= 1'b1;
         if (accept) begin
            half_cnt <= '0;
            edge_cnt <= '0;
            rx_sr    <= '0;
            if (CPHA) begin
               // Bit 7 goes out on the first SCLK edge.
               tx_sr <= spitx;
            end else begin
               // Bit 7 must already be on the line before the first edge.
               tx_sr  <= {spitx[6:0], 1'b0};
               mosi_q <= spitx[7];
            end
         end else if (state == SHIFT) begin
            half_cnt <= half_tc ? '0 : half_cnt + 1'b1;
            if (half_tc) begin
               sclk_q   <= ~sclk_q;
               edge_cnt <= edge_cnt + 5'd1;
            end
            if (shift_now) begin
               mosi_q <= tx_sr[7];
               tx_sr  <= {tx_sr[6:0], 1'b0};
            end
            rx_sr <= rx_next;
            // For CPHA=1 the final sample is taken on the last edge itself.
            // Loading rx_next here makes spirx valid during the DONE cycle.
            if (last_edge) begin
               spirx_q <= rx_next;
            end
         end
      end
   end

endmodule
